vip_bch_enc_sequencer: RTL and testbench
========================================

// Module: vip_bch_enc_sequencer
// PURPOSE
//   Frame sequencer for the systematic binary BCH encoder datapath.
//   - Streams k message bits straight through to the output and feeds each one into a generator-polynomial LFSR.
//   - Then emits the n-k parity bits held in the LFSR.
//   - Sits between the bit-serial message source and the channel/VIP driver.
//   - Generator polynomial comes from the BCH coefficient set (m, t).
// PARAMETERS
//   M_P      4        GF(2^m) field degree; n = 2^M_P-1
//   K_P      7        full-length message bits (BCH(15,7,t=2) default)
//   NK_P     8        parity bits (n-k); equals LFSR length
//   G_POLY_P 9'h1D1   generator g(x), NK_P+1 bits, MSB = x^NK_P (must be 1)
//   KW_P     $clog2(K_P+1)  width of the length config
// PORTS
//   clk        in   1     system clock
//   rst        in   1     asynchronous reset, active-high
//   cfg_k_len  in   KW_P  message length for next frame (shortened code); 0 or >K_P means K_P
//   s_valid    in   1     message bit valid
//   s_ready    out  1     message bit accepted when s_valid & s_ready
//   s_data     in   1     message bit, highest-degree coefficient first
//   m_valid    out  1     codeword bit valid
//   m_ready    in   1     downstream ready
//   m_data     out  1     codeword bit
//   m_last     out  1     high on final parity bit of a frame
//   busy       out  1     high from first accepted message bit until last parity bit handed off
// BEHAVIOUR
//   Reset (async, rst=1):
//     - State MSG, lfsr=0, bit_cnt=0, busy=0.
//     - m_valid=0, m_last=0, m_data=0.
//     - s_ready = m_ready once rst is released.
//     - Frame in flight is discarded, no partial parity emitted.
//   State MSG (combinational pass-through, 0-cycle latency):
//     - m_valid=s_valid, m_data=s_data, s_ready=m_ready, m_last=0.
//     - On handshake: fb=s_data^lfsr[NK_P-1]; lfsr<={lfsr[NK_P-2:0],1'b0}^(fb?G_POLY_P[NK_P-1:0]:0); bit_cnt++.
//     - First handshake of a frame latches k_len_r = sanitised cfg_k_len. cfg changes mid-frame are ignored.
//     - Handshake with bit_cnt==k_len_r-1: bit_cnt<=0, next state PAR.
//   State PAR:
//     - s_ready=0, m_valid=1, m_data=lfsr[NK_P-1], m_last=(bit_cnt==NK_P-1).
//     - On m_ready: lfsr<<=1 (zero fill), bit_cnt++.
//     - Last bit accepted: lfsr=0, bit_cnt=0, state MSG.
//     - The next frame's first bit may hand off in the very next cycle.
//   Backpressure:
//     - m_ready=0 holds m_data/m_last stable in PAR.
//     - In MSG, no bit is consumed while m_ready=0.
//   busy rises on the first MSG handshake and falls in the cycle after the m_last handshake.
//   Throughput: 1 bit/clk sustained; frame = k_len_r+NK_P cycles, no idle gap.
//   Invariant: every emitted frame is a codeword. c(x) mod g(x) = 0, including shortened frames.
// CONFIGURATION
//   VIP_BCH_ENC_FRAME_CNT_EN
//     - Defined: adds output frame_cnt (32 bit, reset 0). Increments on each m_last handshake, wraps 2^32-1 -> 0.
//     - Undefined: port and counter absent. All other behaviour identical.
// STRUCTURE
//   vip_bch_types_pkg:
//     - enum bch_enc_state_t {MSG, PAR}.
//     - Default BCH(15,7) constants: K, NK, G_POLY.
//   vip_bch_constants_pkg:
//     - MIN_M_C/MAX_M_C. Parameters are checked against these by an elaboration-time assertion.
//   Sub-module vip_bch_lfsr_div:
//     - NK_P-bit Galois LFSR divider.
//     - Inputs: shift_en, load_zero, din, mode (divide/shift-out).
//     - Output: msb.
//   Top holds the FSM, counters and handshake muxing.
// TESTING
//   1. k_len=7, msg 1000000 -> codeword 1000000_11101000, m_last on bit 15 only.
//   2. k_len=7, msg 0000000 -> parity 00000000; busy high exactly 15 cycles at full rate.
//   3. cfg_k_len=3, msg 100 -> parity 11100110 (x^10 mod g), m_last on bit 11.
//   4. Random m_ready (50%), 200 random frames:
//      - Each codeword reference-divided by g(x) leaves remainder 0.
//      - s_ready never high in PAR.
//   5. rst asserted mid-PAR (bit 3) -> outputs zero same cycle. Next frame 1000000 gives parity 11101000.
//   6. Back-to-back frames with cfg_k_len changed mid-frame -> change applies only to the next frame.
//      With the macro defined, frame_cnt=2 after two frames.

Source files
------------

// File: rtl/vip_bch_constants_pkg.sv
// Supported GF(2^m) field-degree range for the BCH encoder family.
package vip_bch_constants_pkg;

    localparam int MIN_M_C = 3;
    localparam int MAX_M_C = 16;

endpackage

// File: rtl/vip_bch_types_pkg.sv
// Shared types and default BCH(15,7,t=2) code constants for the BCH encoder sequencer.
package vip_bch_types_pkg;

    typedef enum logic [0:0] {
        MSG = 1'b0,
        PAR = 1'b1
    } bch_enc_state_t;

    localparam int K  = 7;
    localparam int NK = 8;
    localparam logic [8:0] G_POLY = 9'h1D1;

    // LFSR operating modes: divide while the message streams, plain shift while parity drains
    localparam logic MODE_DIV   = 1'b0;
    localparam logic MODE_SHIFT = 1'b1;

endpackage

// File: rtl/vip_bch_enc_param_chk.sv
// Elaboration-time legality checks on the BCH encoder parameter set.
module vip_bch_enc_param_chk
    import vip_bch_constants_pkg::*;
#(
    parameter int M_P  = 4,
    parameter int K_P  = 7,
    parameter int NK_P = 8,
    parameter logic [NK_P:0] G_POLY_P = (NK_P + 1)'(9'h1D1)
) ();

    generate
        if ((M_P < MIN_M_C) || (M_P > MAX_M_C)) begin : g_bad_m
            $error("vip_bch_enc: M_P=%0d outside [%0d,%0d]", M_P, MIN_M_C, MAX_M_C);
        end
        if ((K_P < 1) || (NK_P < 2) || ((K_P + NK_P) > ((2 ** M_P) - 1))) begin : g_bad_len
            $error("vip_bch_enc: K_P=%0d NK_P=%0d do not fit n=2^%0d-1", K_P, NK_P, M_P);
        end
        if (G_POLY_P[NK_P] != 1'b1) begin : g_bad_poly
            $error("vip_bch_enc: generator leading coefficient must be 1");
        end
    endgenerate

endmodule

// File: rtl/vip_bch_lfsr_div.sv
// NK_P-bit Galois LFSR that divides the message by g(x) and then shifts the remainder out MSB first.
module vip_bch_lfsr_div
    import vip_bch_types_pkg::*;
#(
    parameter int NK_P = NK,
    parameter logic [NK_P:0] G_POLY_P = G_POLY
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en,
    input  logic load_zero,
    input  logic din,
    input  logic mode,
    output logic msb
);

    logic [NK_P-1:0] lfsr;
    logic [NK_P-1:0] lfsr_nxt;
    logic            fb;

    // Next-state: clear wins over shift; feedback taps only apply in divide mode
    always_comb begin
        fb       = din ^ lfsr[NK_P-1];
        lfsr_nxt = lfsr;
        if (load_zero) begin
            lfsr_nxt = {NK_P{1'b0}};
        end else if (shift_en) begin
            if ((mode == MODE_DIV) && fb) begin
                lfsr_nxt = {lfsr[NK_P-2:0], 1'b0} ^ G_POLY_P[NK_P-1:0];
            end else begin
                lfsr_nxt = {lfsr[NK_P-2:0], 1'b0};
            end
        end else begin
            lfsr_nxt = lfsr;
        end
    end

    // Remainder register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= {NK_P{1'b0}};
        end else begin
            lfsr <= lfsr_nxt;
        end
    end

    assign msb = lfsr[NK_P-1];

endmodule

// File: rtl/vip_bch_enc_sequencer.sv
// Systematic BCH encoder frame sequencer: message pass-through, then NK_P parity bits.
// Optional frame counter output enabled by defining VIP_BCH_ENC_FRAME_CNT_EN.
module vip_bch_enc_sequencer
    import vip_bch_types_pkg::*;
#(
    parameter int M_P  = 4,
    parameter int K_P  = K,
    parameter int NK_P = NK,
    parameter logic [NK_P:0] G_POLY_P = G_POLY,
    parameter int KW_P = $clog2(K_P + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [KW_P-1:0] cfg_k_len,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic            s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            m_data,
    output logic            m_last,
    output logic            busy
`ifdef VIP_BCH_ENC_FRAME_CNT_EN
    ,
    output logic [31:0]     frame_cnt
`endif
);

    localparam int CW = $clog2(((K_P > NK_P) ? K_P : NK_P) + 1);
    localparam logic [KW_P-1:0] K_FULL = KW_P'(K_P);
    localparam logic [0:0] ST_MSG = MSG;
    localparam logic [0:0] ST_PAR = PAR;

    logic [0:0]      state;
    logic [CW-1:0]   bit_cnt;
    logic [KW_P-1:0] k_len_r;
    logic [KW_P-1:0] cfg_len;
    logic [KW_P-1:0] cur_len;
    logic            busy_r;
    logic            s_hs;
    logic            p_hs;
    logic            last_msg;
    logic            last_par;
    logic            lfsr_msb;
    logic            lfsr_mode;

    vip_bch_enc_param_chk #(
        .M_P      (M_P),
        .K_P      (K_P),
        .NK_P     (NK_P),
        .G_POLY_P (G_POLY_P)
    ) u_param_chk ();

    // Length sanitising; the first bit of a frame must see the live config
    always_comb begin
        if ((cfg_k_len == {KW_P{1'b0}}) || (cfg_k_len > K_FULL)) begin
            cfg_len = K_FULL;
        end else begin
            cfg_len = cfg_k_len;
        end
        if (bit_cnt == {CW{1'b0}}) begin
            cur_len = cfg_len;
        end else begin
            cur_len = k_len_r;
        end
    end

    assign s_hs      = (state == ST_MSG) & s_valid & m_ready;
    assign p_hs      = (state == ST_PAR) & m_ready;
    assign last_msg  = (bit_cnt == (CW'(cur_len) - CW'(1'b1)));
    assign last_par  = (bit_cnt == CW'(NK_P - 1));
    assign lfsr_mode = (state == ST_MSG) ? MODE_DIV : MODE_SHIFT;

    vip_bch_lfsr_div #(
        .NK_P     (NK_P),
        .G_POLY_P (G_POLY_P)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (s_hs | p_hs),
        .load_zero (p_hs & last_par),
        .din       (s_data),
        .mode      (lfsr_mode),
        .msb       (lfsr_msb)
    );

    // Handshake muxing; everything is forced quiet while reset is asserted
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = 1'b0;
        m_last  = 1'b0;
        if (rst) begin
            s_ready = 1'b0;
        end else if (state == ST_MSG) begin
            s_ready = m_ready;
            m_valid = s_valid;
            m_data  = s_data;
        end else begin
            m_valid = 1'b1;
            m_data  = lfsr_msb;
            m_last  = last_par;
        end
    end

    assign busy = ~rst & (busy_r | s_hs);

    // Frame FSM and bit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_MSG;
            bit_cnt <= {CW{1'b0}};
            k_len_r <= K_FULL;
            busy_r  <= 1'b0;
        end else begin
            case (state)
                ST_MSG: begin
                    if (s_hs) begin
                        busy_r <= 1'b1;
                        if (bit_cnt == {CW{1'b0}}) begin
                            k_len_r <= cfg_len;
                        end
                        if (last_msg) begin
                            bit_cnt <= {CW{1'b0}};
                            state   <= ST_PAR;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1'b1);
                        end
                    end
                end
                ST_PAR: begin
                    if (p_hs) begin
                        if (last_par) begin
                            bit_cnt <= {CW{1'b0}};
                            state   <= ST_MSG;
                            busy_r  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1'b1);
                        end
                    end
                end
                default: begin
                    state   <= ST_MSG;
                    bit_cnt <= {CW{1'b0}};
                end
            endcase
        end
    end

`ifdef VIP_BCH_ENC_FRAME_CNT_EN
    // Completed-frame counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 32'd0;
        end else if (p_hs && last_par) begin
            frame_cnt <= frame_cnt + 32'd1;
        end else begin
            frame_cnt <= frame_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_vip_bch_enc_sequencer.sv
// Scoreboard bench for vip_bch_enc_sequencer: expected codewords come from polynomial long division.
module tb_vip_bch_enc_sequencer;

    localparam int K  = 7;
    localparam int NK = 8;
    localparam logic [8:0] G = 9'h1D1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cfg_k_len;
    logic       s_valid, s_ready, s_data;
    logic       m_valid, m_ready, m_data, m_last;
    logic       busy;
`ifdef VIP_BCH_ENC_FRAME_CNT_EN
    logic [31:0] frame_cnt;
    logic [31:0] fc_before;
`endif

    always #5 clk = ~clk;

    vip_bch_enc_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_k_len (cfg_k_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy)
`ifdef VIP_BCH_ENC_FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;
    bit exp_data[$];
    bit exp_last[$];
    bit exp_par[$];
    bit mon_en = 1'b1;
    bit busy_cnt_en = 1'b0;
    int busy_cnt = 0;
    logic [31:0] rx_cw = 32'd0;
    int rx_len = 0;
    logic [31:0] last_cw_rx = 32'd0;
    int last_len_rx = 0;
    int frames_rx = 0;
    int ready_pct = 100;
    int valid_pct = 100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // remainder of p(x) mod g(x); top = highest degree present in p
    function automatic logic [7:0] poly_mod(input logic [31:0] p, input int top);
        logic [31:0] r;
        r = p;
        for (int d = top; d >= NK; d--) begin
            if (r[d]) r = r ^ (32'(G) << (d - NK));
        end
        return r[7:0];
    endfunction

    function automatic int eff_len(input logic [2:0] c);
        if (c == 3'd0 || int'(c) > K) return K;
        return int'(c);
    endfunction

    task automatic monitor();
        bit d, l;
        forever begin
            @(negedge clk);
            if (busy_cnt_en && busy === 1'b1) busy_cnt++;
            if (mon_en && !rst) begin
                if (exp_par.size() > 0 && exp_par[0]) begin
                    check("s_ready_in_par", 32'(s_ready), 32'd0);
                    check("m_valid_in_par", 32'(m_valid), 32'd1);
                end
                if (m_valid && m_ready) begin
                    check("output_expected", 32'(exp_data.size() > 0), 32'd1);
                    if (exp_data.size() > 0) begin
                        d = exp_data.pop_front();
                        l = exp_last.pop_front();
                        void'(exp_par.pop_front());
                        check("m_data", 32'(m_data), 32'(d));
                        check("m_last", 32'(m_last), 32'(l));
                        rx_cw = {rx_cw[30:0], m_data};
                        rx_len++;
                        if (l) begin
                            check("codeword_remainder", 32'(poly_mod(rx_cw, rx_len - 1)), 32'd0);
                            last_cw_rx  = rx_cw;
                            last_len_rx = rx_len;
                            frames_rx++;
                            rx_cw  = 32'd0;
                            rx_len = 0;
                        end
                    end
                end
            end
        end
    endtask

    task automatic step(output bit hs);
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        m_ready = ($urandom_range(99) < ready_pct);
    endtask

    task automatic send_frame(input logic [2:0] cfg, input logic [2:0] cfg_after, input logic [31:0] bits);
        int k, waited;
        logic [31:0] msg;
        logic [7:0] par;
        bit hs;
        k   = eff_len(cfg);
        msg = bits & ((32'd1 << k) - 32'd1);
        par = poly_mod(msg << NK, k + NK - 1);
        for (int i = k - 1; i >= 0; i--) begin
            exp_data.push_back(msg[i]); exp_last.push_back(1'b0); exp_par.push_back(1'b0);
        end
        for (int i = NK - 1; i >= 0; i--) begin
            exp_data.push_back(par[i]); exp_last.push_back(i == 0); exp_par.push_back(1'b1);
        end
        cfg_k_len = cfg;
        for (int i = k - 1; i >= 0; i--) begin
            s_data = msg[i];
            hs = 1'b0;
            waited = 0;
            while (!hs && waited < 200) begin
                s_valid = ($urandom_range(99) < valid_pct);
                step(hs);
                waited++;
            end
            if (!hs) begin
                check("msg_bit_accept_timeout", 32'(hs), 32'd1);
                s_valid = 1'b0;
                return;
            end
            if (i == k - 1) cfg_k_len = cfg_after;
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        bit hs;
        s_valid = 1'b0;
        n = 0;
        while (exp_data.size() > 0 && n < 2000) begin
            step(hs);
            n++;
        end
        if (exp_data.size() > 0) check("drain_timeout", 32'(exp_data.size()), 32'd0);
    endtask

    initial begin
        bit hs;
        cfg_k_len = 3'd7;
        s_valid   = 1'b0;
        s_data    = 1'b0;
        m_ready   = 1'b0;
        fork
            monitor();
        join_none

        // reset state
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("s_ready_follows_m_ready_hi", 32'(s_ready), 32'd1);
        m_ready = 1'b0;
        #1;
        check("s_ready_follows_m_ready_lo", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;

        // test 1: single high-order bit
        send_frame(3'd7, 3'd7, 32'b1000000);
        drain();
        check("t1_parity", {24'd0, last_cw_rx[7:0]}, 32'b11101000);
        check("t1_frame_len", 32'(last_len_rx), 32'd15);

        // test 2: all-zero frame and busy duration
        repeat (3) step(hs);
        busy_cnt = 0;
        busy_cnt_en = 1'b1;
        send_frame(3'd7, 3'd7, 32'd0);
        drain();
        repeat (3) step(hs);
        busy_cnt_en = 1'b0;
        check("t2_busy_cycles", 32'(busy_cnt), 32'd15);
        check("t2_parity", {24'd0, last_cw_rx[7:0]}, 32'd0);

        // test 3: shortened frame
        send_frame(3'd3, 3'd3, 32'b100);
        drain();
        check("t3_parity", {24'd0, last_cw_rx[7:0]}, 32'b11100110);
        check("t3_frame_len", 32'(last_len_rx), 32'd11);

        // test 5: reset in the middle of parity
        mon_en = 1'b0;
        cfg_k_len = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            s_valid = 1'b1;
            s_data  = (i == 6);
            step(hs);
        end
        s_valid = 1'b0;
        repeat (3) step(hs);
        check("t5_par_before_rst", 32'(m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_m_valid", 32'(m_valid), 32'd0);
        check("t5_rst_m_data", 32'(m_data), 32'd0);
        check("t5_rst_m_last", 32'(m_last), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        send_frame(3'd7, 3'd7, 32'b1000000);
        drain();
        check("t5_parity_after_rst", {24'd0, last_cw_rx[7:0]}, 32'b11101000);

        // test 6: back-to-back with mid-frame config change
        begin
            int f0;
            f0 = frames_rx;
`ifdef VIP_BCH_ENC_FRAME_CNT_EN
            fc_before = frame_cnt;
`endif
            send_frame(3'd3, 3'd5, $urandom);
            send_frame(3'd5, 3'd1, $urandom);
            drain();
            check("t6_frames", 32'(frames_rx - f0), 32'd2);
            check("t6_second_len", 32'(last_len_rx), 32'd13);
`ifdef VIP_BCH_ENC_FRAME_CNT_EN
            check("t6_frame_cnt", frame_cnt - fc_before, 32'd2);
`endif
        end

        // test 4: random traffic with backpressure
        ready_pct = 50;
        valid_pct = 75;
        for (int f = 0; f < 200; f++) begin
            send_frame(3'($urandom_range(7)), 3'($urandom_range(7)), $urandom);
        end
        drain();
        ready_pct = 100;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
